// File: rtl/booth_psum_acc_if.sv
// Bus bundle for booth_psum_acc: multiplier capture, neighbour psum input and psum output handshake.
// The slave modport is the accumulator side, the master modport is whoever drives it.
interface booth_psum_acc_if #(
  parameter int PROD_W = 32,
  parameter int ACC_W  = 40,
  parameter int LEN_W  = 4
);
  logic              start;
  logic [LEN_W-1:0]  cfg_len;
  logic [PROD_W-1:0] prod_in;
  logic              prod_done;
  logic [ACC_W-1:0]  psum_in;
  logic              psum_in_vld;
  logic              psum_in_rdy;
  logic [ACC_W-1:0]  psum_out;
  logic              psum_out_vld;
  logic              psum_out_rdy;
  logic              busy;
  logic              ovf;
  logic              drop;

  modport master (
    output start, cfg_len, prod_in, prod_done, psum_in, psum_in_vld, psum_out_rdy,
    input  psum_in_rdy, psum_out, psum_out_vld, busy, ovf, drop
  );

  modport slave (
    input  start, cfg_len, prod_in, prod_done, psum_in, psum_in_vld, psum_out_rdy,
    output psum_in_rdy, psum_out, psum_out_vld, busy, ovf, drop
  );
endinterface

// File: rtl/booth_psum_acc.sv
// Saturating partial-sum accumulator behind the radix-4 Booth multiplier of a PE.
// Define BOOTH_PSUM_CHAIN_EN to merge the neighbouring PE's psum before output.
module booth_psum_acc #(
  parameter int PROD_W = 32,
  parameter int ACC_W  = 40,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rstn,
  booth_psum_acc_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ACC, MERGE, OUT} state_t;

  state_t                   state;
  logic                     done_q;
  logic                     pe;
  logic [LEN_W-1:0]         len_q;
  logic [LEN_W-1:0]         cnt;
  logic [ACC_W-1:0]         acc;
  logic [ACC_W-1:0]         prod_ext;
  logic [ACC_W:0]           sum_p;
  logic                     out_vld_q;
  logic                     busy_q;
  logic                     ovf_q;
  logic                     drop_q;

  // Returns {overflow, clamped sum}; the add is done one bit wider so the carry-out sign is exact.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b);
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (s[ACC_W] != s[ACC_W-1])
      return {1'b1, s[ACC_W], {(ACC_W-1){~s[ACC_W]}}};
    return {1'b0, s[ACC_W-1:0]};
  endfunction

  assign pe       = bus.prod_done & ~done_q;
  assign prod_ext = ACC_W'($signed(bus.prod_in));
  assign sum_p    = sat_add(acc, prod_ext);

`ifdef BOOTH_PSUM_CHAIN_EN
  logic           in_rdy_q;
  logic [ACC_W:0] sum_m;
  assign sum_m           = sat_add(acc, bus.psum_in);
  assign bus.psum_in_rdy = in_rdy_q;
`else
  logic unused_chain;
  assign unused_chain    = ^{bus.psum_in, bus.psum_in_vld};
  assign bus.psum_in_rdy = 1'b0;
`endif

  assign bus.psum_out     = acc;
  assign bus.psum_out_vld = out_vld_q;
  assign bus.busy         = busy_q;
  assign bus.ovf          = ovf_q;
  assign bus.drop         = drop_q;

  // NOTE: every register here is state, so all of them are written with <= and cleared by the async reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      done_q    <= 1'b0;
      len_q     <= '0;
      cnt       <= '0;
      acc       <= '0;
      out_vld_q <= 1'b0;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
      drop_q    <= 1'b0;
`ifdef BOOTH_PSUM_CHAIN_EN
      in_rdy_q  <= 1'b0;
`endif
    end else begin
      done_q <= bus.prod_done;
      case (state)
        IDLE: begin
          if (bus.start) begin
            len_q  <= bus.cfg_len;
            acc    <= '0;
            cnt    <= '0;
            ovf_q  <= 1'b0;
            drop_q <= pe;    // a product edge coinciding with start is still discarded
            busy_q <= 1'b1;
            if (bus.cfg_len != '0) begin
              state <= ACC;
            end else begin
`ifdef BOOTH_PSUM_CHAIN_EN
              state    <= MERGE;
              in_rdy_q <= 1'b1;
`else
              state     <= OUT;
              out_vld_q <= 1'b1;
`endif
            end
          end else if (pe) begin
            drop_q <= 1'b1;
          end
        end

        ACC: begin
          if (pe) begin
            acc   <= sum_p[ACC_W-1:0];
            ovf_q <= ovf_q | sum_p[ACC_W];
            cnt   <= cnt + 1'b1;
            if (LEN_W'(cnt + 1'b1) == len_q) begin
`ifdef BOOTH_PSUM_CHAIN_EN
              state    <= MERGE;
              in_rdy_q <= 1'b1;
`else
              state     <= OUT;
              out_vld_q <= 1'b1;
`endif
            end
          end
        end

`ifdef BOOTH_PSUM_CHAIN_EN
        MERGE: begin
          if (pe) drop_q <= 1'b1;
          if (bus.psum_in_vld) begin
            acc       <= sum_m[ACC_W-1:0];
            ovf_q     <= ovf_q | sum_m[ACC_W];
            in_rdy_q  <= 1'b0;
            out_vld_q <= 1'b1;
            state     <= OUT;
          end
        end
`endif

        OUT: begin
          if (pe) drop_q <= 1'b1;
          if (bus.psum_out_rdy) begin
            out_vld_q <= 1'b0;
            busy_q    <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_psum_acc.sv
// Randomized self-checking bench for booth_psum_acc against an integer reference model.
// Chain-dependent expectations follow BOOTH_PSUM_CHAIN_EN, matching the RTL build.
module tb_booth_psum_acc;
  localparam int P = 16;
  localparam int A = 18;
  localparam int L = 4;
  localparam longint MAXV = (64'sd1 <<< (A-1)) - 1;
  localparam longint MINV = -(64'sd1 <<< (A-1));

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  booth_psum_acc_if #(.PROD_W(P), .ACC_W(A), .LEN_W(L)) bus ();
  booth_psum_acc #(.PROD_W(P), .ACC_W(A), .LEN_W(L)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  int     total = 0;
  int     bad   = 0;
  longint m_acc;
  bit     m_ovf;
  bit     m_drop;
  longint prods [16];

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer sum clamped after every addition.
  function automatic longint sat(input longint v);
    if (v > MAXV) begin m_ovf = 1'b1; return MAXV; end
    if (v < MINV) begin m_ovf = 1'b1; return MINV; end
    return v;
  endfunction

  function automatic longint rnd_prod(input bit full);
    logic [P-1:0] r;
    r = P'($urandom);
    if (full) return longint'($signed(r));
    return longint'($urandom_range(0, 400)) - 200;
  endfunction

  task automatic tick;
    @(negedge clk);
  endtask

  // mode 0: mid-psum product, 1: last product, 2: stray edge (no check)
  task automatic pulse_product(input longint p, input int hold, input int mode);
    bus.prod_in   = P'(p);
    bus.prod_done = 1'b1;
    tick();
    if (mode == 0) begin
      check("acc_no_early_vld", longint'(bus.psum_out_vld), 0);
    end else if (mode == 1) begin
`ifdef BOOTH_PSUM_CHAIN_EN
      check("merge_rdy_after_last", longint'(bus.psum_in_rdy), 1);
`else
      check("vld_latency_last_pe", longint'(bus.psum_out_vld), 1);
`endif
    end
    repeat (hold - 1) tick();
    bus.prod_done = 1'b0;
    tick();
  endtask

  task automatic run_psum(input int len, input longint chain_v, input int chain_dly,
                          input int bp, input bit extra, input bit st_hs,
                          input bit st_pe, input bit st_acc, input int max_hold);
    m_acc = 0; m_ovf = 1'b0; m_drop = 1'b0;
    bus.cfg_len = L'(len);
    bus.start   = 1'b1;
    if (st_pe) begin
      bus.prod_in   = P'(1234);
      bus.prod_done = 1'b1;
      m_drop        = 1'b1;
    end
    tick();
    bus.start     = 1'b0;
    bus.prod_done = 1'b0;
    check("busy_after_start", longint'(bus.busy), 1);
    if (st_pe) tick();

    for (int i = 0; i < len; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      if (st_acc && i == 1) begin
        bus.cfg_len = L'(~len);
        bus.start   = 1'b1;
        tick();
        bus.start   = 1'b0;
      end
      pulse_product(prods[i], $urandom_range(1, max_hold), (i == len - 1) ? 1 : 0);
      m_acc = sat(m_acc + prods[i]);
    end

`ifdef BOOTH_PSUM_CHAIN_EN
    repeat (chain_dly) tick();
    check("merge_rdy_wait", longint'(bus.psum_in_rdy), 1);
    check("merge_no_vld", longint'(bus.psum_out_vld), 0);
    bus.psum_in     = A'(chain_v);
    bus.psum_in_vld = 1'b1;
    tick();
    bus.psum_in_vld = 1'b0;
    check("chain_vld_latency", longint'(bus.psum_out_vld), 1);
    check("chain_rdy_drop", longint'(bus.psum_in_rdy), 0);
    m_acc = sat(m_acc + chain_v);
`else
    check("nochain_rdy_zero", longint'(bus.psum_in_rdy), 0);
    if (chain_v != 0 || chain_dly != 0) begin
      bus.psum_in     = A'(chain_v);
      bus.psum_in_vld = 1'b1;
      tick();
      bus.psum_in_vld = 1'b0;
    end
`endif

    begin
      int k;
      for (k = 0; k < 20 && !bus.psum_out_vld; k++) tick();
      check("out_vld_timeout", longint'(bus.psum_out_vld), 1);
    end

    for (int c = 0; c < bp; c++) begin
      if (extra && c == bp / 2) begin
        pulse_product(rnd_prod(1'b1), 1, 2);
        m_drop = 1'b1;
      end else begin
        tick();
      end
    end
    check("psum_out", $signed(bus.psum_out), m_acc);
    check("ovf", longint'(bus.ovf), longint'(m_ovf));
    check("drop", longint'(bus.drop), longint'(m_drop));
    check("vld_held", longint'(bus.psum_out_vld), 1);

    bus.psum_out_rdy = 1'b1;
    bus.start        = st_hs;
    bus.cfg_len      = L'(3);
    tick();
    bus.psum_out_rdy = 1'b0;
    bus.start        = 1'b0;
    check("vld_drop_after_hs", longint'(bus.psum_out_vld), 0);
    check("idle_after_hs", longint'(bus.busy), 0);
    check("ovf_sticky_idle", longint'(bus.ovf), longint'(m_ovf));
    check("drop_sticky_idle", longint'(bus.drop), longint'(m_drop));
  endtask

  initial begin
    bus.start = 1'b0; bus.cfg_len = '0; bus.prod_in = '0; bus.prod_done = 1'b0;
    bus.psum_in = '0; bus.psum_in_vld = 1'b0; bus.psum_out_rdy = 1'b0;
    repeat (3) tick();
    check("rst_busy", longint'(bus.busy), 0);
    check("rst_vld", longint'(bus.psum_out_vld), 0);
    check("rst_psum", longint'(bus.psum_out), 0);
    check("rst_ovf", longint'(bus.ovf), 0);
    check("rst_drop", longint'(bus.drop), 0);
    check("rst_rdy", longint'(bus.psum_in_rdy), 0);
    rstn = 1'b1;
    tick();

    // 5 - 7 + 100
    prods[0] = 5; prods[1] = -7; prods[2] = 100;
    run_psum(3, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    check("t1_const", m_acc, 98);

    // Chain delayed 4 cycles; in the default build psum_in is ignored.
    prods[0] = 10; prods[1] = 20;
    run_psum(2, -50, 4, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1);

    // prod_done held 5 cycles counts once
    prods[0] = 7; prods[1] = 9;
    run_psum(2, 0, 1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 5);

    // Back-pressure 10 cycles with an extra edge, start during handshake
    prods[0] = -3;
    run_psum(1, 0, 0, 10, 1'b1, 1'b1, 1'b0, 1'b0, 1);

    // Saturation both ways, including clamp-then-recover
    for (int i = 0; i < 15; i++) prods[i] = -32768;
    run_psum(15, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    check("sat_neg_const", m_acc, MINV);
    for (int i = 0; i < 5; i++) prods[i] = 32767;
    prods[5] = -32768;
    run_psum(6, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    check("sat_recover_const", m_acc, MAXV - 32768);
`ifdef BOOTH_PSUM_CHAIN_EN
    prods[0] = 32767; prods[1] = 32767;
    run_psum(2, MAXV - 10, 2, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    check("sat_chain_const", m_acc, MAXV);
`endif

    // Stray edge in IDLE, then start together with an edge, start inside ACC
    pulse_product(55, 1, 2);
    check("idle_pe_drop", longint'(bus.drop), 1);
    check("idle_pe_busy", longint'(bus.busy), 0);
    prods[0] = 11; prods[1] = 22; prods[2] = 33;
    run_psum(3, 0, 0, 1, 1'b0, 1'b0, 1'b1, 1'b1, 2);

    // Asynchronous reset mid-ACC
    bus.cfg_len = L'(3); bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    pulse_product(77, 1, 0);
    #2 rstn = 1'b0;
    #1;
    check("arst_busy", longint'(bus.busy), 0);
    check("arst_psum", longint'(bus.psum_out), 0);
    check("arst_vld", longint'(bus.psum_out_vld), 0);
    check("arst_ovf", longint'(bus.ovf), 0);
    check("arst_drop", longint'(bus.drop), 0);
    tick();
    rstn = 1'b1;
    tick();
    run_psum(0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    check("len0_const", m_acc, 0);

    // Random psums
    for (int it = 0; it < 40; it++) begin
      int len;
      bit full;
      longint cv;
      len  = $urandom_range(0, 15);
      full = ($urandom_range(0, 2) == 0);
      for (int i = 0; i < len; i++) prods[i] = rnd_prod(full);
      cv = longint'($urandom_range(0, 2 * 131071)) - 131071;
      run_psum(len, cv, $urandom_range(0, 4), $urandom_range(0, 6),
               ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1,
               ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0),
               $urandom_range(1, 4));
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0d exp=%0d", 1, 0);
    $fatal(1, "timeout");
  end
endmodule
